system_on_chip_top: RTL and testbench
=====================================

SYSTEM_ON_CHIP_TOP -- requirements
Module: system_on_chip

Interface
REQ-001 The block SHALL have parameter DATA_BUS_LEN, default 32: width of the data bus, flash words and CPU registers.
REQ-002 The block SHALL have parameter FLASH_DATA_LEN, default 16: width of the immediate field in the low bits of each instruction word.
REQ-003 The block SHALL have parameter FLASH_DEPTH, default 256: number of flash words.
REQ-004 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port FLASH_IN, input, DATA_BUS_LEN bits: instruction word to program.
REQ-007 The block SHALL have port FLASH_ADDR, input, DATA_BUS_LEN bits: flash address to program; only the low log2(FLASH_DEPTH) bits are used.
REQ-008 The block SHALL have port FLASH_WR, input, 1 bit: flash write enable.
REQ-009 The block SHALL expose the internal instance "flash" with output OUT, the word at the current PC.
REQ-010 The block SHALL expose the internal instance "processor" with outputs REG1_OUT and REG2_OUT, holding R1 and R2.

Function
REQ-011 The instruction word SHALL be {opcode[31:16], imm[15:0]}.
REQ-012 Immediates SHALL be zero-extended to 32 bits before use.
REQ-013 Opcode encodings SHALL be:
- NOP = 0x0000
- LD_R1_FROM_FLASH = 0x0001
- LD_R2_FROM_FLASH = 0x0002
- R2_ADD_CONST = 0x0003
- R1_SUB_CONST = 0x0004
- R1_EQ_CONSTANT = 0x0005
- LD_PC_FROM_INSTR = 0x0006
REQ-014 Undefined opcodes SHALL execute as NOP.
REQ-015 On a rising edge with FLASH_WR=1, flash[FLASH_ADDR] SHALL be written with FLASH_IN; repeated writes to the same address are allowed.
REQ-016 Flash contents SHALL be all-zero at power-up, i.e. unprogrammed words are NOP.
REQ-017 RST SHALL NOT alter flash contents.
REQ-018 Flash read SHALL be asynchronous: flash.OUT = flash[PC], with zero cycle read latency.
REQ-019 The processor SHALL execute exactly one instruction per clock while RST=0 and FLASH_WR=0.
REQ-020 While FLASH_WR=1, the processor SHALL stall: PC, R1, R2 and FLAG are held.
REQ-021 LD_R1_FROM_FLASH SHALL load R1 with imm and set PC to PC+1.
REQ-022 LD_R2_FROM_FLASH SHALL load R2 with imm and set PC to PC+1.
REQ-023 R2_ADD_CONST SHALL set R2 to R2+imm, modulo 2^32, and set PC to PC+1.
REQ-024 R1_SUB_CONST SHALL set R1 to R1-imm, modulo 2^32 with wrap on underflow, and set PC to PC+1.
REQ-025 R1_EQ_CONSTANT SHALL set FLAG to (R1 == imm) and set PC to PC+1.
REQ-026 LD_PC_FROM_INSTR SHALL be a conditional jump: if FLAG=0, PC is set to imm; if FLAG=1, PC is set to PC+1. FLAG is unchanged.
REQ-027 NOP SHALL set PC to PC+1 only.
REQ-028 FLAG SHALL be modified only by R1_EQ_CONSTANT.
REQ-029 PC SHALL be log2(FLASH_DEPTH) bits wide and wrap from FLASH_DEPTH-1 to 0.
REQ-030 A jump target SHALL use the low log2(FLASH_DEPTH) bits of imm.

Reset
REQ-031 On a rising edge with RST=1, the block SHALL set PC=0, R1=0, R2=0 and FLAG=0.
REQ-032 RST SHALL take priority over execution and over the FLASH_WR stall.
REQ-033 Reset asserted mid-program SHALL restart execution at address 0 on the first edge after RST deasserts.
REQ-034 A write on the same edge as RST=1 SHALL still update flash.

Verification
REQ-035 Multiply loop: program the following, then apply RST for 2 edges and release. After 30 executed instructions, R1 SHALL be 0 and R2 SHALL be 0x31. At 31 cycles, flash.OUT SHALL equal 0x00000000.
- addr 0: LD_R1 7
- addr 1: LD_R2 0
- addr 2: R2_ADD 7
- addr 3: R1_SUB 1
- addr 4: R1_EQ 0
- addr 5: LD_PC 2
- addr 6-9: NOP
REQ-036 Flag set: R1=5, execute R1_EQ 5 then LD_PC 0x20. PC SHALL advance sequentially; no jump is taken.
REQ-037 Underflow: R1=0, execute R1_SUB 1. R1 SHALL be 0xFFFFFFFF.
REQ-038 Stall: assert FLASH_WR mid-run for 3 cycles. PC, R1 and R2 SHALL be frozen, then resume from the same PC.
REQ-039 Reset persistence: program flash, assert RST mid-loop. Registers SHALL be zeroed, flash SHALL be intact, and a rerun SHALL give the same final R2=0x31.
REQ-040 Wrap: an empty flash run for 256 cycles SHALL return PC to 0 with R1=R2=0.

Source files
------------

// File: rtl/system_on_chip_top.sv
// Tiny programmable SoC: a write-programmed instruction flash feeding a
// single-cycle accumulator-style processor with registers R1, R2 and FLAG.

module soc_flash #(
  parameter int DATA_BUS_LEN = 32,
  parameter int FLASH_DEPTH  = 256,
  parameter int ADDR_W       = $clog2(FLASH_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    WR,
  input  logic [ADDR_W-1:0]       WADDR,
  input  logic [DATA_BUS_LEN-1:0] DIN,
  input  logic [ADDR_W-1:0]       RADDR,
  output logic [DATA_BUS_LEN-1:0] OUT
);

  // Power-up contents are all-zero (NOP); reset deliberately leaves them alone.
  logic [DATA_BUS_LEN-1:0] mem_q [FLASH_DEPTH] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (WR) mem_q[WADDR] <= DIN;
  end

  assign OUT = mem_q[RADDR];

endmodule

module soc_processor #(
  parameter int DATA_BUS_LEN   = 32,
  parameter int FLASH_DATA_LEN = 16,
  parameter int FLASH_DEPTH    = 256,
  parameter int ADDR_W         = $clog2(FLASH_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    STALL,
  input  logic [DATA_BUS_LEN-1:0] INSTR,
  output logic [ADDR_W-1:0]       PC_OUT,
  output logic [DATA_BUS_LEN-1:0] REG1_OUT,
  output logic [DATA_BUS_LEN-1:0] REG2_OUT,
  output logic                    FLAG_OUT
);

  localparam int OPC_W = DATA_BUS_LEN - FLASH_DATA_LEN;

  localparam logic [OPC_W-1:0] OP_LD_R1  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD_R2  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_R2_ADD = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_R1_SUB = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_R1_EQ  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LD_PC  = OPC_W'(6);

  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [DATA_BUS_LEN-1:0]   r1_q, r1_d;
  logic [DATA_BUS_LEN-1:0]   r2_q, r2_d;
  logic                      flag_q, flag_d;
  logic [OPC_W-1:0]          opcode;
  logic [FLASH_DATA_LEN-1:0] imm;
  logic [DATA_BUS_LEN-1:0]   imm_ext;

  assign opcode  = INSTR[DATA_BUS_LEN-1:FLASH_DATA_LEN];
  assign imm     = INSTR[FLASH_DATA_LEN-1:0];
  assign imm_ext = {{OPC_W{1'b0}}, imm};

  always_comb begin
    pc_d   = pc_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    flag_d = flag_q;
    if (!STALL) begin
      pc_d = pc_q + 1'b1;
      case (opcode)
        OP_LD_R1:  r1_d   = imm_ext;
        OP_LD_R2:  r2_d   = imm_ext;
        OP_R2_ADD: r2_d   = r2_q + imm_ext;
        OP_R1_SUB: r1_d   = r1_q - imm_ext;
        OP_R1_EQ:  flag_d = (r1_q == imm_ext);
        // Jump is taken only when the last compare failed.
        OP_LD_PC:  if (!flag_q) pc_d = imm[ADDR_W-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      flag_q <= flag_d;
    end
  end

  assign PC_OUT   = pc_q;
  assign REG1_OUT = r1_q;
  assign REG2_OUT = r2_q;
  assign FLAG_OUT = flag_q;

endmodule

module system_on_chip_top #(
  parameter int DATA_BUS_LEN   = 32,
  parameter int FLASH_DATA_LEN = 16,
  parameter int FLASH_DEPTH    = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_BUS_LEN-1:0] FLASH_IN,
  input  logic [DATA_BUS_LEN-1:0] FLASH_ADDR,
  input  logic                    FLASH_WR
);

  localparam int ADDR_W = $clog2(FLASH_DEPTH);

  logic [ADDR_W-1:0]       pc;
  logic [DATA_BUS_LEN-1:0] instr;
  logic [DATA_BUS_LEN-1:0] reg1, reg2;
  logic                    flag;
  logic                    unused_addr_hi;

  // Only the low address bits select a flash word.
  assign unused_addr_hi = ^{FLASH_ADDR[DATA_BUS_LEN-1:ADDR_W], reg1, reg2, flag};

  soc_flash #(
    .DATA_BUS_LEN (DATA_BUS_LEN),
    .FLASH_DEPTH  (FLASH_DEPTH)
  ) flash (
    .CLK   (CLK),
    .WR    (FLASH_WR),
    .WADDR (FLASH_ADDR[ADDR_W-1:0]),
    .DIN   (FLASH_IN),
    .RADDR (pc),
    .OUT   (instr)
  );

  soc_processor #(
    .DATA_BUS_LEN   (DATA_BUS_LEN),
    .FLASH_DATA_LEN (FLASH_DATA_LEN),
    .FLASH_DEPTH    (FLASH_DEPTH)
  ) processor (
    .CLK      (CLK),
    .RST      (RST),
    .STALL    (FLASH_WR),
    .INSTR    (instr),
    .PC_OUT   (pc),
    .REG1_OUT (reg1),
    .REG2_OUT (reg2),
    .FLAG_OUT (flag)
  );

endmodule

// File: tb/tb_system_on_chip_top.sv
// Directed bench for system_on_chip_top: programs small flash images and
// checks PC, R1, R2, FLAG and flash.OUT against hand-computed values.

module tb_system_on_chip_top;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] FLASH_IN = '0;
  logic [31:0] FLASH_ADDR = '0;
  logic        FLASH_WR = 1'b0;

  int total = 0;
  int bad   = 0;

  system_on_chip_top dut (
    .CLK        (CLK),
    .RST        (RST),
    .FLASH_IN   (FLASH_IN),
    .FLASH_ADDR (FLASH_ADDR),
    .FLASH_WR   (FLASH_WR)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    FLASH_WR   = 1'b1;
    FLASH_ADDR = addr;
    FLASH_IN   = data;
    tick(1);
    FLASH_WR   = 1'b0;
  endtask

  function automatic logic [31:0] pc();
    return {24'h0, dut.processor.pc_q};
  endfunction

  function automatic logic [31:0] r1();
    return dut.processor.REG1_OUT;
  endfunction

  function automatic logic [31:0] r2();
    return dut.processor.REG2_OUT;
  endfunction

  function automatic logic [31:0] flg();
    return {31'h0, dut.processor.flag_q};
  endfunction

  initial begin
    // Reset state with empty flash
    tick(2);
    chk("rst_pc", pc(), 32'h0);
    chk("rst_r1", r1(), 32'h0);
    chk("rst_r2", r2(), 32'h0);
    chk("rst_flag", flg(), 32'h0);
    chk("rst_out", dut.flash.OUT, 32'h0);

    // Empty flash: PC walks all 256 words and wraps
    RST = 1'b0;
    tick(255);
    chk("wrap_pc255", pc(), 32'hFF);
    tick(1);
    chk("wrap_pc0", pc(), 32'h0);
    chk("wrap_r1", r1(), 32'h0);
    chk("wrap_r2", r2(), 32'h0);

    // Program multiply loop while in reset (writes must land during RST)
    RST = 1'b1;
    prog(0, 32'h0001_0007);
    prog(1, 32'h0002_0000);
    prog(2, 32'h0003_0007);
    prog(3, 32'h0004_0001);
    prog(4, 32'h0005_0000);
    prog(5, 32'h0006_0002);
    tick(2);
    chk("mul_rst_out", dut.flash.OUT, 32'h0001_0007);
    RST = 1'b0;
    tick(2);
    chk("mul_init_r1", r1(), 32'd7);
    chk("mul_init_pc", pc(), 32'd2);
    tick(4);
    chk("mul_it1_r1", r1(), 32'd6);
    chk("mul_it1_r2", r2(), 32'd7);
    chk("mul_it1_pc", pc(), 32'd2);
    tick(24);
    chk("mul_r1", r1(), 32'h0);
    chk("mul_r2", r2(), 32'h31);
    chk("mul_flag", flg(), 32'h1);
    chk("mul_pc30", pc(), 32'd6);
    tick(1);
    chk("mul_out31", dut.flash.OUT, 32'h0);
    chk("mul_pc31", pc(), 32'd7);

    // Stall: FLASH_WR held 3 cycles mid-loop freezes the processor
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(4);
    chk("stall_pre_pc", pc(), 32'd4);
    FLASH_WR = 1'b1;
    FLASH_ADDR = 32'd200;
    FLASH_IN = 32'hDEAD_0000;
    tick(3);
    FLASH_WR = 1'b0;
    chk("stall_pc", pc(), 32'd4);
    chk("stall_r1", r1(), 32'd6);
    chk("stall_r2", r2(), 32'd7);
    tick(1);
    chk("resume_pc", pc(), 32'd5);
    tick(1);
    chk("resume_jmp", pc(), 32'd2);

    // Reset mid-loop: registers cleared, flash intact, rerun matches
    tick(3);
    RST = 1'b1;
    tick(1);
    chk("rp_pc", pc(), 32'h0);
    chk("rp_r1", r1(), 32'h0);
    chk("rp_r2", r2(), 32'h0);
    chk("rp_out", dut.flash.OUT, 32'h0001_0007);
    RST = 1'b0;
    tick(30);
    chk("rp_final_r1", r1(), 32'h0);
    chk("rp_final_r2", r2(), 32'h31);

    // Reset wins over the write stall; new program for flag/underflow/etc.
    tick(1);
    chk("pre_prog_pc", pc(), 32'd7);
    RST = 1'b1;
    prog(0, 32'h0001_0005);
    chk("rst_over_wr_pc", pc(), 32'h0);
    prog(1, 32'h0005_0005);
    prog(2, 32'h0006_0020);
    prog(3, 32'h0001_0000);
    prog(4, 32'h0004_0001);
    prog(5, 32'h00FF_1234);
    prog(6, 32'h0002_8000);
    prog(7, 32'h0003_FFFF);
    prog(8, 32'h0005_0000);
    prog(9, 32'h0006_0105);
    tick(1);
    RST = 1'b0;
    tick(2);
    chk("feq_flag", flg(), 32'h1);
    tick(1);
    chk("nojump_pc", pc(), 32'd3);
    chk("nojump_flag", flg(), 32'h1);
    tick(2);
    chk("underflow_r1", r1(), 32'hFFFF_FFFF);
    tick(1);
    chk("undef_pc", pc(), 32'd6);
    chk("undef_r1", r1(), 32'hFFFF_FFFF);
    chk("undef_flag", flg(), 32'h1);
    tick(1);
    chk("zext_r2", r2(), 32'h0000_8000);
    tick(1);
    chk("add_r2", r2(), 32'h0001_7FFF);
    tick(1);
    chk("neq_flag", flg(), 32'h0);
    tick(1);
    chk("jmp_low_bits", pc(), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
